// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: upstream and regfile-side signals of the writeback stage
interface regfile_writeback_if #(
  parameter int PTR_W = 2
);
  logic          AluWrite;
  logic [4:0]    AluRegister;
  logic [31:0]   AluData;
  logic          LongValid;
  logic          LongReady;
  logic [4:0]    LongRegister;
  logic [31:0]   LongData;
  logic          AluStall;
  logic          RegWrite;
  logic [4:0]    WriteRegister;
  logic [31:0]   WriteData;
  logic [31:0]   Pending;
  logic [PTR_W:0] Count;
  modport master (
    output AluWrite, AluRegister, AluData, LongValid, LongRegister, LongData,
    input  LongReady, AluStall, RegWrite, WriteRegister, WriteData, Pending, Count
  );
  modport slave (
    input  AluWrite, AluRegister, AluData, LongValid, LongRegister, LongData,
    output LongReady, AluStall, RegWrite, WriteRegister, WriteData, Pending, Count
  );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: merges ALU and queued long-latency results onto the single regfile write port
module regfile_writeback #(
  parameter int DEPTH        = 4,
  parameter int PTR_W        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic           Clk,
  input logic           Reset,
  regfile_writeback_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [4:0]       r_reg [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic [SW-1:0]    r_starve;
  logic             r_stall, r_reg_write;
  logic [4:0]       r_wr_reg;
  logic [31:0]      r_wr_data;
  logic             w_push, w_alu, w_pop, w_busy, w_starved;
  logic [DEPTH-1:0] w_valid;
  logic [31:0]      w_pending;

  assign bus.LongReady = r_count != (PTR_W+1)'(DEPTH);
  assign w_push    = bus.LongValid && bus.LongReady && bus.LongRegister != 5'd0;
  assign w_alu     = !r_stall && bus.AluWrite && bus.AluRegister != 5'd0;
  assign w_busy    = r_count != '0;
  assign w_pop     = !w_alu && w_busy;
  assign w_starved = w_alu && w_busy && r_starve == SW'(STARVE_LIMIT - 1);

  // An entry is live when its distance from the read pointer is below the occupancy
  for (genvar k = 0; k < DEPTH; k++) begin : g_valid
    logic [PTR_W-1:0] w_off;
    assign w_off      = PTR_W'(k) - r_rd_ptr;
    assign w_valid[k] = {1'b0, w_off} < r_count;
  end

  // Pending mask: OR of destinations of every live entry, so duplicates keep the bit set
  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) if (w_valid[i]) w_pending[r_reg[i]] = 1'b1;
  end

  // FIFO storage; not reset because liveness comes from the pointers and count
  always_ff @(posedge Clk)
    if (!Reset && w_push) begin
      r_reg[r_wr_ptr]  <= bus.LongRegister;
      r_data[r_wr_ptr] <= bus.LongData;
    end

  // Pointers, occupancy, starvation tracking and the registered write port
  always_ff @(posedge Clk)
    if (Reset) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_starve    <= '0;
      r_stall     <= 1'b0;
      r_reg_write <= 1'b0;
      r_wr_reg    <= '0;
      r_wr_data   <= '0;
    end else begin
      r_rd_ptr    <= r_rd_ptr + PTR_W'(w_pop);
      r_wr_ptr    <= r_wr_ptr + PTR_W'(w_push);
      r_count     <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      r_starve    <= (w_pop || !w_busy || w_starved) ? '0 : w_alu ? r_starve + 1'b1 : r_starve;
      r_stall     <= w_starved;
      r_reg_write <= w_alu || w_pop;
      if (w_alu) begin
        r_wr_reg  <= bus.AluRegister;
        r_wr_data <= bus.AluData;
      end else if (w_pop) begin
        r_wr_reg  <= r_reg[r_rd_ptr];
        r_wr_data <= r_data[r_rd_ptr];
      end
    end

  assign bus.AluStall      = r_stall;
  assign bus.RegWrite      = r_reg_write;
  assign bus.WriteRegister = r_wr_reg;
  assign bus.WriteData     = r_wr_data;
  assign bus.Pending       = w_pending;
  assign bus.Count         = r_count;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: randomized and directed checks against a queue-based writeback model
module tb_regfile_writeback;
  localparam int DEPTH = 4, PTR_W = 2, LIMIT = 8;
  localparam int VW = 1 + 5 + 32 + 1 + PTR_W + 1 + 32 + 1;
  typedef struct packed {logic [4:0] r; logic [31:0] d;} ent_t;

  logic Clk = 1'b0, Reset = 1'b1;
  regfile_writeback_if #(.PTR_W(PTR_W)) bus();
  regfile_writeback #(.DEPTH(DEPTH), .PTR_W(PTR_W), .STARVE_LIMIT(LIMIT)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );
  always #5 Clk = ~Clk;

  ent_t        q[$];
  bit          m_stall, m_rw;
  int          m_starve;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  int          n_chk, n_fail, n_stall;
  int          seen_reg[$];
  logic [31:0] seen_data[$];
  logic [VW-1:0] obs;

  assign obs = {bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.AluStall,
                bus.Count, bus.Pending, bus.LongReady};

  function automatic logic [VW-1:0] exp_vec();
    logic [31:0] p = '0;
    foreach (q[i]) p[q[i].r] = 1'b1;
    return {m_rw, m_wr, m_wd, m_stall, (PTR_W+1)'(q.size()), p, q.size() != DEPTH};
  endfunction

  task automatic drive(input logic aw, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    bus.AluWrite = aw; bus.AluRegister = ar; bus.AluData = ad;
    bus.LongValid = lv; bus.LongRegister = lr; bus.LongData = ld;
  endtask

  task automatic tick();
    bit full, alu, pop, busy, nstall;
    ent_t e;
    @(posedge Clk);
    if (Reset) begin
      q.delete(); m_stall = 0; m_starve = 0; m_rw = 0; m_wr = '0; m_wd = '0;
    end else begin
      busy = q.size() > 0;
      full = q.size() == DEPTH;
      alu = !m_stall && bus.AluWrite && bus.AluRegister != 0;
      pop = !alu && busy;
      nstall = 0;
      if (pop || !busy) m_starve = 0;
      else if (alu) begin
        m_starve += 1;
        if (m_starve == LIMIT) begin nstall = 1; m_starve = 0; end
      end
      if (alu) begin m_rw = 1; m_wr = bus.AluRegister; m_wd = bus.AluData; end
      else if (pop) begin e = q.pop_front(); m_rw = 1; m_wr = e.r; m_wd = e.d; end
      else m_rw = 0;
      if (bus.LongValid && !full && bus.LongRegister != 0) q.push_back({bus.LongRegister, bus.LongData});
      m_stall = nstall;
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(1'b1, 5'($urandom), $urandom, 1'b1, 5'($urandom), $urandom);
    repeat (2) tick();
    n_chk++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL reset_vec: got %h expected %h", obs, exp_vec()); end
    n_chk++;
    if ({bus.Count, bus.LongReady, bus.RegWrite, bus.Pending, bus.AluStall} !== {3'd0, 1'b1, 1'b0, 32'd0, 1'b0}) begin
      n_fail++; $display("FAIL reset_state: count %0d ready %b rw %b pending %h stall %b", bus.Count, bus.LongReady, bus.RegWrite, bus.Pending, bus.AluStall);
    end
    Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_alu_write();
    drive(1, 5'd2, 32'd42, 0, 0, 0);
    tick();
    n_chk++;
    if (obs !== exp_vec()) begin n_fail++; $display("FAIL alu_vec: got %h expected %h", obs, exp_vec()); end
    n_chk++;
    if ({bus.RegWrite, bus.WriteRegister, bus.WriteData} !== {1'b1, 5'd2, 32'd42}) begin
      n_fail++; $display("FAIL alu_write: got rw %b reg %0d data %0d expected 1 2 42", bus.RegWrite, bus.WriteRegister, bus.WriteData);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_chk++;
    if ({bus.RegWrite, bus.WriteData} !== {1'b0, 32'd42}) begin
      n_fail++; $display("FAIL alu_idle: got rw %b data %0d expected 0 42", bus.RegWrite, bus.WriteData);
    end
  endtask

  task automatic test_long_single();
    drive(0, 0, 0, 1, 5'd5, 32'd15);
    tick();
    n_chk++;
    if ({bus.Pending, bus.Count, bus.RegWrite} !== {32'h20, 3'd1, 1'b0}) begin
      n_fail++; $display("FAIL long_push: got pending %h count %0d rw %b expected 00000020 1 0", bus.Pending, bus.Count, bus.RegWrite);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_chk++;
    if ({bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.Pending, bus.Count} !== {1'b1, 5'd5, 32'd15, 32'd0, 3'd0}) begin
      n_fail++; $display("FAIL long_pop: got rw %b reg %0d data %0d pending %h count %0d", bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.Pending, bus.Count);
    end
  endtask

  task automatic test_starvation();
    seen_reg.delete(); seen_data.delete(); n_stall = 0;
    for (int i = 0; i < 50; i++) begin
      drive(1, 5'd3, $urandom, i < 7, i < 4 ? 5'(6 + i) : 5'd10, i < 4 ? 32'(100 + i) : 32'd999);
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL starve_vec cyc %0d: got %h expected %h", i, obs, exp_vec()); end
      if (i >= 4 && i < 7) begin
        n_chk++;
        if ({bus.Count, bus.LongReady} !== {3'd4, 1'b0}) begin
          n_fail++; $display("FAIL full_block cyc %0d: got count %0d ready %b expected 4 0", i, bus.Count, bus.LongReady);
        end
      end
      if (bus.AluStall) n_stall++;
      if (bus.RegWrite && bus.WriteRegister != 5'd3) begin seen_reg.push_back(bus.WriteRegister); seen_data.push_back(bus.WriteData); end
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    n_chk++;
    if (n_stall != 4) begin n_fail++; $display("FAIL stall_count: got %0d expected 4", n_stall); end
    n_chk++;
    if (seen_reg.size() != 4) begin n_fail++; $display("FAIL drain_len: got %0d expected 4", seen_reg.size()); end
    else for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (seen_reg[i] != 6 + i || seen_data[i] !== 32'(100 + i)) begin
        n_fail++; $display("FAIL drain_order %0d: got reg %0d data %0d expected %0d %0d", i, seen_reg[i], seen_data[i], 6 + i, 100 + i);
      end
    end
  endtask

  task automatic test_zero_reg();
    drive(1, 5'd0, 32'd15, 1, 5'd0, 32'd77);
    repeat (3) begin
      tick();
      n_chk++;
      if ({bus.RegWrite, bus.Count, bus.Pending} !== {1'b0, 3'd0, 32'd0}) begin
        n_fail++; $display("FAIL zero_reg: got rw %b count %0d pending %h expected 0 0 0", bus.RegWrite, bus.Count, bus.Pending);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    seen_reg.delete(); seen_data.delete();
    drive(1, 5'd3, $urandom, 1, 5'd11, 32'd200);
    tick();
    drive(1, 5'd3, $urandom, 1, 5'd12, 32'd201);
    tick();
    for (int j = 0; j < 6; j++) begin
      drive(0, 0, 0, 1, 5'(13 + j), 32'(202 + j));
      tick();
      n_chk++;
      if (obs !== exp_vec() || bus.Count !== 3'd2) begin
        n_fail++; $display("FAIL b2b cyc %0d: got %h count %0d expected %h count 2", j, obs, bus.Count, exp_vec());
      end
      if (bus.RegWrite) begin seen_reg.push_back(bus.WriteRegister); seen_data.push_back(bus.WriteData); end
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) begin
      tick();
      if (bus.RegWrite) begin seen_reg.push_back(bus.WriteRegister); seen_data.push_back(bus.WriteData); end
    end
    n_chk++;
    if (seen_reg.size() != 8) begin n_fail++; $display("FAIL b2b_len: got %0d expected 8", seen_reg.size()); end
    else for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (seen_reg[i] != 11 + i || seen_data[i] !== 32'(200 + i)) begin
        n_fail++; $display("FAIL b2b_order %0d: got reg %0d data %0d expected %0d %0d", i, seen_reg[i], seen_data[i], 11 + i, 200 + i);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd3, $urandom, 1, 5'(20 + i), 32'(300 + i));
      tick();
    end
    n_chk++;
    if ({bus.Count, bus.RegWrite} !== {3'd3, 1'b1}) begin
      n_fail++; $display("FAIL pre_reset: got count %0d rw %b expected 3 1", bus.Count, bus.RegWrite);
    end
    Reset = 1'b1;
    drive(1, 5'd4, $urandom, 1, 5'd23, $urandom);
    tick();
    n_chk++;
    if ({bus.Count, bus.Pending, bus.RegWrite, bus.LongReady} !== {3'd0, 32'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL mid_reset: got count %0d pending %h rw %b ready %b", bus.Count, bus.Pending, bus.RegWrite, bus.LongReady);
    end
    Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) begin
      tick();
      n_chk++;
      if (bus.RegWrite !== 1'b0) begin n_fail++; $display("FAIL discarded_write: got rw %b reg %0d expected rw 0", bus.RegWrite, bus.WriteRegister); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Reset = $urandom_range(0, 99) == 0;
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
      tick();
      n_chk++;
      if (obs !== exp_vec()) begin n_fail++; $display("FAIL random cyc %0d: got %h expected %h", i, obs, exp_vec()); end
    end
    Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_long_single();
    test_starvation();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
